// File: rtl/student_id_scroller.sv
// Scrolls the hex digits of an ID across NUM_DISP seven-segment positions (IDLE/SCROLL/PAUSE).
// Optional macro SCROLL_GAP_EN appends two blank gap elements to the scrolled sequence.
module student_id_scroller #(
   parameter logic [31:0] ID          = 32'h0812_3456,
   parameter int          ID_LEN      = 8,
   parameter int          NUM_DISP    = 6,
   parameter int          TICK_CYCLES = 25_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  step,
   output logic [4*NUM_DISP-1:0] digits,
   output logic [NUM_DISP-1:0]   blank,
   output logic                  scrolling
);

`ifdef SCROLL_GAP_EN
   localparam int L = ID_LEN + 2;
`else
   localparam int L = ID_LEN;
`endif
   localparam int OFF_W = (L > 1) ? $clog2(L) : 1;
   localparam int PRE_W = $clog2(TICK_CYCLES);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(L - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SCROLL, ST_PAUSE} state_e;

   // Element i of the sequence; indices at or beyond ID_LEN are gap elements.
   function automatic logic [3:0] elem_digit(input int i);
      if (i < ID_LEN) elem_digit = 4'(ID >> (28 - 4 * i));
      else elem_digit = 4'h0;
   endfunction

   function automatic logic [4*NUM_DISP-1:0] pattern_digits(input int o);
      logic [4*NUM_DISP-1:0] res;
      res = '0;
      for (int k = 0; k < NUM_DISP; k++) res[4*k +: 4] = elem_digit((o + k) % L);
      return res;
   endfunction

   function automatic logic [OFF_W-1:0] off_inc(input logic [OFF_W-1:0] o);
      off_inc = (o == OFF_LAST) ? '0 : o + OFF_W'(1);
   endfunction

   localparam logic [4*NUM_DISP-1:0] RST_DIGITS = pattern_digits(0);

   state_e                state_q, state_d;
   logic [OFF_W-1:0]      off_q, off_d;
   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [4*NUM_DISP-1:0] digits_q, digits_d;
   logic                  scroll_q, scroll_d;
   logic                  tick;

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      pre_d   = '0;
      tick    = (state_q == ST_SCROLL) && (pre_q == PRE_LAST);
      case (state_q)
         ST_IDLE: begin
            off_d = '0;
            if (!stop) begin
               if (start) begin
                  state_d = ST_SCROLL;
               end else if (step) begin
                  off_d   = off_inc('0);
                  state_d = ST_PAUSE;
               end
            end
         end
         ST_SCROLL: begin
            // A tick that coincides with stop still advances the offset.
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (tick) off_d = off_inc(off_q);
            if (stop) begin
               state_d = ST_PAUSE;
               pre_d   = '0;
            end
         end
         ST_PAUSE: begin
            if (stop) begin
               state_d = ST_IDLE;
               off_d   = '0;
            end else if (start) begin
               state_d = ST_SCROLL;
            end else if (step) begin
               off_d = off_inc(off_q);
            end
         end
         default: begin
            state_d = ST_IDLE;
            off_d   = '0;
         end
      endcase
   end

   always_comb begin
      digits_d = RST_DIGITS;
      for (int o = 0; o < L; o++) begin
         if (off_d == OFF_W'(o)) digits_d = pattern_digits(o);
      end
      scroll_d = (state_d == ST_SCROLL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         off_q    <= '0;
         pre_q    <= '0;
         digits_q <= RST_DIGITS;
         scroll_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         off_q    <= off_d;
         pre_q    <= pre_d;
         digits_q <= digits_d;
         scroll_q <= scroll_d;
      end
   end

   assign digits    = digits_q;
   assign scrolling = scroll_q;

`ifdef SCROLL_GAP_EN
   function automatic logic [NUM_DISP-1:0] pattern_blank(input int o);
      logic [NUM_DISP-1:0] res;
      res = '0;
      for (int k = 0; k < NUM_DISP; k++) res[k] = (((o + k) % L) >= ID_LEN);
      return res;
   endfunction

   localparam logic [NUM_DISP-1:0] RST_BLANK = pattern_blank(0);

   logic [NUM_DISP-1:0] blank_q, blank_d;

   always_comb begin
      blank_d = RST_BLANK;
      for (int o = 0; o < L; o++) begin
         if (off_d == OFF_W'(o)) blank_d = pattern_blank(o);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blank_q <= RST_BLANK;
      else blank_q <= blank_d;
   end

   assign blank = blank_q;
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_student_id_scroller.sv
// Randomised and directed bench for student_id_scroller, with a sequence-level reference model.
module tb_student_id_scroller;

   localparam logic [31:0] ID      = 32'h0812_3456;
   localparam int          ID_LEN  = 8;
   localparam int          ND      = 6;
   localparam int          TICKS   = 4;
`ifdef SCROLL_GAP_EN
   localparam int          ML      = ID_LEN + 2;
`else
   localparam int          ML      = ID_LEN;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            stop = 1'b0;
   logic            step = 1'b0;
   logic [4*ND-1:0] digits;
   logic [ND-1:0]   blank;
   logic            scrolling;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the sequence as arrays, plus where we are in it.
   logic [3:0] seq_digit[ML];
   bit         seq_gap[ML];
   int         m_off;
   bit         m_run;
   bit         m_held;
   int         m_cnt;

   student_id_scroller #(
      .ID(ID), .ID_LEN(ID_LEN), .NUM_DISP(ND), .TICK_CYCLES(TICKS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
      .digits(digits), .blank(blank), .scrolling(scrolling)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [4*ND-1:0] exp_digits(input int off);
      logic [4*ND-1:0] d;
      d = '0;
      for (int k = 0; k < ND; k++) d[4*k +: 4] = seq_digit[(off + k) % ML];
      return d;
   endfunction

   function automatic logic [ND-1:0] exp_blank(input int off);
      logic [ND-1:0] b;
      b = '0;
      for (int k = 0; k < ND; k++) b[k] = seq_gap[(off + k) % ML];
      return b;
   endfunction

   task automatic model_reset();
      m_off = 0; m_run = 0; m_held = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit sk);
      if (m_run) begin
         m_cnt++;
         if (m_cnt == TICKS) begin
            m_off = (m_off + 1) % ML;
            m_cnt = 0;
         end
         if (sp) begin
            m_run = 0; m_held = 1;
         end
      end else if (m_held) begin
         if (sp) begin
            m_held = 0; m_off = 0;
         end else if (st) begin
            m_run = 1; m_held = 0; m_cnt = 0;
         end else if (sk) begin
            m_off = (m_off + 1) % ML;
         end
      end else if (!sp) begin
         if (st) begin
            m_run = 1; m_cnt = 0;
         end else if (sk) begin
            m_off = 1 % ML; m_held = 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".digits"}, 32'(digits), 32'(exp_digits(m_off)));
      check({tag, ".blank"}, 32'(blank), 32'(exp_blank(m_off)));
      check({tag, ".scrolling"}, 32'(scrolling), 32'(m_run));
   endtask

   // One clock: drive pulses, take the edge, update the model, compare #1 later.
   task automatic do_cycle(input bit st, input bit sp, input bit sk, input string tag);
      start = st; stop = sp; step = sk;
      @(posedge clk);
      model_step(st, sp, sk);
      #1;
      start = 0; stop = 0; step = 0;
      check_model(tag);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) do_cycle(0, 0, 0, tag);
   endtask

   task automatic apply_reset(input string tag);
      #3;
      rst_n = 0;
      model_reset();
      #1;
      check({tag, ".rst_digits"}, 32'(digits), 32'(exp_digits(0)));
      check({tag, ".rst_blank"}, 32'(blank), 32'(exp_blank(0)));
      check({tag, ".rst_scrolling"}, 32'(scrolling), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      check_model({tag, ".post_rst"});
   endtask

   initial begin
      for (int i = 0; i < ML; i++) begin
         if (i < ID_LEN) begin
            seq_digit[i] = ID[31 - 4*i -: 4];
            seq_gap[i]   = 0;
         end else begin
            seq_digit[i] = 4'h0;
            seq_gap[i]   = 1;
         end
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("por.digits", 32'(digits), 32'h0043_2180);
      check("por.scrolling", 32'(scrolling), 32'(0));
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

`ifndef SCROLL_GAP_EN
      do_cycle(1, 0, 0, "start");
      check("start.scrolling", 32'(scrolling), 32'(1));
      idle_cycles(3, "first_tick_wait");
      check("before_tick.digits", 32'(digits), 32'h0043_2180);
      do_cycle(0, 0, 0, "first_tick");
      check("first_tick.digits", 32'(digits), 32'h0054_3218);
      idle_cycles(6 * TICKS, "wrap_run");
      check("seven_ticks.digits", 32'(digits), 32'h0032_1806);
      idle_cycles(TICKS, "wrap");
      check("wrap.digits", 32'(digits), 32'h0043_2180);
      idle_cycles(TICKS, "tick_again");
      do_cycle(0, 1, 0, "stop_to_pause");
      check("pause.scrolling", 32'(scrolling), 32'(0));
      idle_cycles(12, "pause_hold");
      check("pause_hold.digits", 32'(digits), 32'h0054_3218);
      do_cycle(0, 0, 1, "pause_step");
      check("pause_step.digits", 32'(digits), 32'h0065_4321);
      do_cycle(0, 1, 0, "pause_stop");
      check("to_idle.digits", 32'(digits), 32'h0043_2180);
      do_cycle(1, 1, 0, "idle_start_stop");
      check("idle_start_stop.scrolling", 32'(scrolling), 32'(0));
      idle_cycles(TICKS + 1, "idle_hold");
      check("idle_hold.digits", 32'(digits), 32'h0043_2180);
      do_cycle(0, 0, 1, "idle_step");
      check("idle_step.digits", 32'(digits), 32'h0054_3218);
      check("idle_step.scrolling", 32'(scrolling), 32'(0));
      do_cycle(1, 0, 0, "resume");
      idle_cycles(TICKS - 1, "resume_wait");
      do_cycle(0, 1, 0, "tick_with_stop");
      check("tick_with_stop.digits", 32'(digits), 32'h0065_4321);
      do_cycle(0, 1, 0, "back_idle");
`else
      for (int i = 0; i < 4; i++) do_cycle(0, 0, 1, "gap_step");
      check("gap4.digits", 32'(digits), 32'h0000_6543);
      check("gap4.blank", 32'(blank), 32'(6'b110000));
      for (int i = 0; i < 6; i++) do_cycle(0, 0, 1, "gap_step2");
      check("gap10.digits", 32'(digits), 32'h0043_2180);
      check("gap10.blank", 32'(blank), 32'(6'b000000));
      do_cycle(0, 1, 0, "gap_idle");
`endif

      do_cycle(1, 0, 0, "pre_reset_start");
      idle_cycles(2 * TICKS + 1, "pre_reset_run");
      apply_reset("mid_scroll");

      for (int i = 0; i < 1500; i++) begin
         bit st, sp, sk;
         st = ($urandom_range(0, 11) == 0);
         sp = ($urandom_range(0, 15) == 0);
         sk = ($urandom_range(0, 5) == 0);
         do_cycle(st, sp, sk, "rand");
         if ($urandom_range(0, 399) == 0) apply_reset("rand_reset");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/student_id_scroller.md
STUDENT_ID_SCROLLER -- requirements
Module: student_id_scroller

Interface
REQ-001 The block SHALL have these parameters:
- ID, default 32'h0812_3456: eight hex digits; digit 0 is bits [31:28], the leftmost.
- ID_LEN, default 8: number of valid ID digits, range 1..8, taken from the top of ID.
- NUM_DISP, default 6: number of display positions.
- TICK_CYCLES, default 25_000_000: clock cycles per scroll step, minimum 2.

REQ-002 The block SHALL have these ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin or resume scrolling.
- stop  input  1  single-cycle request to pause, or to return to idle.
- step  input  1  single-cycle request to advance one position while not scrolling.
- digits  output  4*NUM_DISP  hex code for each position; position k is in bits [4k+3:4k], and k=0 is the leftmost position.
- blank  output  NUM_DISP  bit k high means position k shows nothing.
- scrolling  output  1  high while in state SCROLL.

REQ-003 The block SHALL feed one seven-segment decoder per position, so each 4-bit digit field carries values 4'h0-4'hF.

Function
REQ-004 The block SHALL hold a registered offset, and a sequence length L, where L = ID_LEN (see REQ-019 for the alternative).

REQ-005 The block SHALL make position k show sequence element (offset+k) mod L, which wraps around for any ID_LEN versus NUM_DISP relationship.

REQ-006 The block SHALL register digits, blank and scrolling, and SHALL update them on the same edge that updates the offset or state.

REQ-007 The block SHALL implement three states:
- IDLE: offset is held at 0.
- SCROLL: offset advances automatically.
- PAUSE: offset is held.

REQ-008 In IDLE, the block SHALL apply these transitions:
- start: go to SCROLL.
- step: offset becomes 1 mod L, and go to PAUSE.
- stop: ignored.

REQ-009 In SCROLL, the block SHALL apply these transitions:
- Prescaler reaches TICK_CYCLES-1: offset becomes (offset+1) mod L, and the prescaler goes to 0.
- stop: go to PAUSE with offset held.
- start and step: ignored.

REQ-010 In PAUSE, the block SHALL apply these transitions:
- start: go to SCROLL.
- step: offset becomes (offset+1) mod L, and stay in PAUSE.
- stop: go to IDLE with offset 0.

REQ-011 The block SHALL give pulses this priority when several arrive in the same cycle: stop first, then start, then step. A prescaler tick coinciding with stop SHALL still advance the offset.

REQ-012 The block SHALL clear the prescaler on every entry to SCROLL, so the first advance occurs exactly TICK_CYCLES cycles after the start pulse is sampled.

REQ-013 The block SHALL hold the prescaler at 0 outside SCROLL.

REQ-014 The block SHALL size the prescaler to $clog2(TICK_CYCLES) bits, and SHALL size the offset to $clog2(L) bits with a minimum of 1.

REQ-015 The block SHALL perform the wrap check (offset == L-1, next value 0) before incrementing; the offset SHALL never hold a value ≥ L.

Reset
REQ-016 On rst_n low, the block SHALL immediately and asynchronously enter IDLE, with offset 0 and prescaler 0.

REQ-017 On rst_n low, digits SHALL show sequence elements 0..NUM_DISP-1 (24'h432180 for the defaults), blank SHALL equal the element blanking for offset 0, and scrolling SHALL be 0.

REQ-018 Reset asserted mid-scroll SHALL discard the offset. After release, the block SHALL ignore the first cycle's pulses only if they coincide with rst_n low.

Configuration
REQ-019 With macro SCROLL_GAP_EN defined, the block SHALL use L = ID_LEN+2. Elements ID_LEN and ID_LEN+1 SHALL be gap elements, showing digit 4'h0 with the blank bit set to 1.

REQ-020 With SCROLL_GAP_EN undefined, the block SHALL use L = ID_LEN, SHALL tie blank to all zeros, and SHALL synthesise no gap logic.

Verification
REQ-021 The bench SHALL cover these scenarios, using default parameters except TICK_CYCLES=4 and macro undefined unless noted:
- Reset: assert rst_n low asynchronously mid-cycle -> digits=24'h432180, blank=0, scrolling=0, with no clock edge needed.
- Start, single step: start pulse -> scrolling=1 next cycle; exactly 4 cycles after start, digits=24'h543218.
- Start, full wrap: start, then 7 ticks -> digits=24'h321806; after the 8th tick -> 24'h432180 (wrap).
- Pause and manual step: start, one tick, stop -> 12 cycles with no change; then step -> digits=24'h654321; then stop -> IDLE with digits=24'h432180.
- Simultaneous start and stop in IDLE -> remains in IDLE with scrolling=0; step in IDLE -> PAUSE with digits=24'h543218.
- SCROLL_GAP_EN defined: four step pulses -> digits shows positions 3,4,5,6 then gap, gap; blank=6'b110000; six more steps -> offset 0 and blank=6'b000000.
